// File: rtl/flexbex_pkg.sv
// Shared types and sizes for the flexbex data-memory bridge.
// Optional feature (see flexbex_dmem_bridge): FLEXBEX_DMEM_ERR_EN.
package flexbex_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned DMEM_WORD_AW = 8;
  localparam int unsigned DMEM_BYTES   = 1024;
  localparam int unsigned WAIT_CW      = 2;

endpackage

// File: rtl/flexbex_wait_cnt.sv
// Loadable down-counter used to stretch the request-to-grant latency.
// Holds at zero; o_zero flags the grant cycle while the bridge waits.
module flexbex_wait_cnt
  import flexbex_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               i_load,
  input  logic [WAIT_CW-1:0] i_load_val,
  input  logic               i_dec,
  output logic               o_zero
);

  logic [WAIT_CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WAIT_CW'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/flexbex_dmem_bridge.sv
// Bridges the ibex data port onto a 1 KB single-port SRAM with optional wait states.
// Define FLEXBEX_DMEM_ERR_EN to answer out-of-window accesses with an error response.
module flexbex_dmem_bridge
  import flexbex_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic        data_err_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        sram_csb0_o,
  output logic        sram_web0_o,
  output logic [3:0]  sram_wmask0_o,
  output logic [7:0]  sram_addr0_o,
  output logic [31:0] sram_din0_o,
  input  logic [31:0] sram_dout0_i
);

  localparam logic               WS_ZERO = (WAIT_STATES == 0);
  localparam logic [WAIT_CW-1:0] WS_LOAD = (WAIT_STATES == 0) ? '0 : WAIT_CW'(WAIT_STATES - 1);

  state_e      r_state;
  logic        r_rvalid;
  logic        r_resp_we;
  logic        r_resp_err;

  logic [31:0] w_offset;
  logic        w_oor;
  logic        w_req_phase;
  logic        w_cnt_zero;
  logic        w_load;
  logic        w_dec;
  logic        w_gnt;

  assign w_offset = data_addr_i - BASE_ADDR;

`ifdef FLEXBEX_DMEM_ERR_EN
  // Unsigned wrap makes addresses below BASE_ADDR land out of range as well.
  assign w_oor = (w_offset >= 32'(DMEM_BYTES));
  logic w_unused_lo;
  assign w_unused_lo = ^w_offset[1:0];
`else
  assign w_oor = 1'b0;
  logic w_unused_bits;
  assign w_unused_bits = ^{w_offset[31:DMEM_WORD_AW+2], w_offset[1:0]};
`endif

  assign w_req_phase = (r_state == ST_IDLE) || (r_state == ST_RESP);
  assign w_load      = resetn && data_req_i && w_req_phase && !WS_ZERO;
  assign w_dec       = (r_state == ST_WAIT);

  // Grant is combinational so a zero-wait request is accepted in its own cycle.
  assign w_gnt = resetn && data_req_i &&
                 ((w_req_phase && WS_ZERO) || ((r_state == ST_WAIT) && w_cnt_zero));

  flexbex_wait_cnt u_wait_cnt (
    .clk        (clk),
    .resetn     (resetn),
    .i_load     (w_load),
    .i_load_val (WS_LOAD),
    .i_dec      (w_dec),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_rvalid   <= 1'b0;
      r_resp_we  <= 1'b0;
      r_resp_err <= 1'b0;
    end else begin
      r_rvalid <= w_gnt;
      if (w_gnt) begin
        r_resp_we  <= data_we_i;
        r_resp_err <= w_oor;
      end
      case (r_state)
        ST_IDLE, ST_RESP: begin
          if (!data_req_i)  r_state <= ST_IDLE;
          else if (WS_ZERO) r_state <= ST_RESP;
          else              r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!data_req_i)     r_state <= ST_IDLE;
          else if (w_cnt_zero) r_state <= ST_RESP;
          else                 r_state <= ST_WAIT;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign data_gnt_o    = w_gnt;
  assign data_rvalid_o = r_rvalid;
  assign data_err_o    = r_rvalid & r_resp_err;
  assign data_rdata_o  = (r_rvalid && !r_resp_we && !r_resp_err) ? sram_dout0_i : '0;

  // SRAM is only selected in the grant cycle of an in-window access.
  assign sram_csb0_o   = ~(w_gnt & ~w_oor);
  assign sram_web0_o   = ~(w_gnt & data_we_i);
  assign sram_wmask0_o = w_gnt ? data_be_i : '0;
  assign sram_addr0_o  = w_offset[DMEM_WORD_AW+1:2];
  assign sram_din0_o   = w_gnt ? data_wdata_i : '0;

endmodule

// File: doc/flexbex_dmem_bridge.md
FLEXBEX_DMEM_BRIDGE -- requirements
Module: flexbex_dmem_bridge

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-low: port clk (rising edge) and port resetn (synchronous, active-low).
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, byte base of the 1 KB data window.
REQ-003 Parameter WAIT_STATES, default 0, range 0..3, cycles inserted between request and grant.
REQ-004 Port clk  in  1  core and SRAM clock.
REQ-005 Port resetn  in  1  synchronous active-low reset.
REQ-006 Port data_req_i  in  1  core data request.
REQ-007 Port data_gnt_o  out  1  request accepted this cycle.
REQ-008 Port data_rvalid_o  out  1  response valid.
REQ-009 Port data_err_o  out  1  response is an error; qualified by rvalid.
REQ-010 Ports data_we_i in 1, data_be_i in 4, data_addr_i in 32, data_wdata_i in 32: core request fields.
REQ-011 Port data_rdata_o  out  32  read data; qualified by rvalid.
REQ-012 Ports sram_csb0_o out 1, sram_web0_o out 1, sram_wmask0_o out 4, sram_addr0_o out 8, sram_din0_o out 32: SRAM port 0 (active-low csb/web).
REQ-013 Port sram_dout0_i  in  32  SRAM port 0 read data, valid one cycle after access.

Function
REQ-014 SHALL implement FSM IDLE, WAIT, RESP.
REQ-015 IDLE/RESP with data_req_i=1: WAIT_STATES=0 -> gnt same cycle; otherwise -> WAIT, counter loaded with WAIT_STATES-1.
REQ-016 WAIT: counter decrements each cycle; gnt asserted in the cycle the counter is 0; request fields sampled in that cycle.
REQ-017 Requests SHALL hold stable until gnt; data_req_i dropping in WAIT returns the FSM to IDLE with no access.
REQ-018 A granted access SHALL go to RESP; data_rvalid_o=1 for exactly one cycle, the cycle after gnt.
REQ-019 RESP without a new grant -> IDLE; back-to-back grant in RESP SHALL be allowed (one rvalid per gnt, one outstanding maximum).
REQ-020 SRAM drive in the gnt cycle only: csb0=0, web0=~data_we_i, wmask0=data_be_i, addr0=(data_addr_i-BASE_ADDR)[9:2], din0=data_wdata_i; otherwise csb0=1, web0=1.
REQ-021 Read response: data_rdata_o=sram_dout0_i; write response: data_rdata_o=0.
REQ-022 Byte offset bits [1:0] ignored; data_be_i SHALL select lanes.

Reset
REQ-023 While resetn=0 at a clk edge: state IDLE, counter 0, data_gnt_o=0, data_rvalid_o=0, data_err_o=0, data_rdata_o=0, sram_csb0_o=1, sram_web0_o=1.
REQ-024 Reset mid-transaction SHALL discard the pending response; no rvalid after reset release without a new gnt.

Configuration
REQ-025 Macro FLEXBEX_DMEM_ERR_EN defined: an address outside [BASE_ADDR, BASE_ADDR+1023] SHALL be granted normally with csb0=1, then answered with rvalid=1, err=1, rdata=0.
REQ-026 Macro FLEXBEX_DMEM_ERR_EN undefined: no range check; upper address bits ignored (aliasing); data_err_o tied 0.

Structure
REQ-027 Shared package flexbex_pkg SHALL hold the FSM state enum, DMEM_WORD_AW=8, and DMEM_BYTES=1024.
REQ-028 One sub-module, flexbex_wait_cnt: loadable down-counter with zero flag.
REQ-029 Instantiated between ibex_core data port and the sky130 1 KB SRAM, replacing the constant rvalid tie-off.

Verification
REQ-030 WAIT_STATES=0: write addr 0x10, wdata 0xDEADBEEF, be 4'hF. Required: gnt same cycle; csb0=0, web0=0, addr0=0x04; rvalid next cycle with rdata=0. Then read 0x10: rvalid+1, rdata=0xDEADBEEF.
REQ-031 Byte write: be=4'b0010, wdata 0x0000AA00 to 0x10. Required: read returns 0xDEADAAEF.
REQ-032 WAIT_STATES=2: hold req. Required: gnt on third request cycle, rvalid on fourth; drop req after one cycle -> no gnt, csb0 stays 1.
REQ-033 Back-to-back reads 0x0, 0x4, 0x8 with WAIT_STATES=0. Required: gnt three consecutive cycles; three consecutive rvalid cycles; data in order.
REQ-034 FLEXBEX_DMEM_ERR_EN defined: read 0x400. Required: gnt, csb0=1, rvalid next with err=1, rdata=0. Undefined: same read aliases to 0x0.
REQ-035 Assert resetn=0 in the gnt cycle of a read. Required: no rvalid afterwards; all outputs at REQ-023 values.
